// File: rtl/mb_pixel_addr_gen.sv
// ---------------------------------------------------------------------------
// mb_pixel_addr_gen
//
// Purpose:
//   Walks a whole frame macroblock by macroblock (macroblocks in raster
//   order) and emits one absolute (x, y) pixel coordinate per accepted beat.
//   Inside each 16x16 macroblock the pixels are visited either in plain
//   raster order (mode 0) or in H.264 4x4-block order (mode 1). A
//   valid/ready handshake lets downstream stall the walk, and the stream is
//   framed with first/last-of-macroblock and last-of-frame markers.
//
// Parameters:
//   FRAME_W   frame width in pixels (multiple of 16)
//   FRAME_H   frame height in pixels (multiple of 16)
//   COORD_W   width of x_out / y_out
//   MB_IDX_W  width of mb_x / mb_y
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       one-cycle request to scan a frame (honoured only when idle)
//   mode        scan mode, sampled together with start
//   ready       downstream accepts the current beat
//   valid       x_out/y_out/markers are valid
//   x_out       absolute pixel column
//   y_out       absolute pixel row
//   mb_x        current macroblock column
//   mb_y        current macroblock row
//   blk_idx     current 4x4 block index inside the macroblock
//   mb_first    beat is the first pixel of its macroblock
//   mb_last     beat is the last pixel of its macroblock
//   frame_last  beat is the last pixel of the frame
//   busy        scan in progress (including the done cycle)
//   done        one-cycle pulse after the final beat is accepted
// ---------------------------------------------------------------------------
module mb_pixel_addr_gen #(
    parameter int FRAME_W  = 176,
    parameter int FRAME_H  = 144,
    parameter int COORD_W  = 32,
    parameter int MB_IDX_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic                ready,
    output logic                valid,
    output logic [COORD_W-1:0]  x_out,
    output logic [COORD_W-1:0]  y_out,
    output logic [MB_IDX_W-1:0] mb_x,
    output logic [MB_IDX_W-1:0] mb_y,
    output logic [3:0]          blk_idx,
    output logic                mb_first,
    output logic                mb_last,
    output logic                frame_last,
    output logic                busy,
    output logic                done
);

    localparam int MB_COLS = FRAME_W / 16;
    localparam int MB_ROWS = FRAME_H / 16;
    localparam logic [MB_IDX_W-1:0] MB_X_MAX = MB_IDX_W'(MB_COLS - 1);
    localparam logic [MB_IDX_W-1:0] MB_Y_MAX = MB_IDX_W'(MB_ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Control state and walk counters
    state_t              state_q,  state_d;
    logic                mode_q,   mode_d;
    logic [7:0]          k_q,      k_d;
    logic [MB_IDX_W-1:0] mbx_q,    mbx_d;
    logic [MB_IDX_W-1:0] mby_q,    mby_d;

    // Registered outputs
    logic                valid_q,      valid_d;
    logic [COORD_W-1:0]  x_out_q,      x_out_d;
    logic [COORD_W-1:0]  y_out_q,      y_out_d;
    logic [MB_IDX_W-1:0] mb_x_q,       mb_x_d;
    logic [MB_IDX_W-1:0] mb_y_q,       mb_y_d;
    logic [3:0]          blk_idx_q,    blk_idx_d;
    logic                mb_first_q,   mb_first_d;
    logic                mb_last_q,    mb_last_d;
    logic                frame_last_q, frame_last_d;
    logic                busy_q,       busy_d;
    logic                done_q,       done_d;

    // Helper terms
    logic       beat_accept;
    logic       at_frame_end;
    logic       run_d;
    logic [3:0] blk_d;
    logic [3:0] pix_d;
    logic [3:0] ox_d;
    logic [3:0] oy_d;

    // A beat is only presented while running, so the handshake reduces to
    // ready in RUN. The frame ends on the last pixel of the bottom-right
    // macroblock, decided from the counters describing the current beat.
    always_comb begin
        beat_accept  = (state_q == ST_RUN) && ready;
        at_frame_end = (k_q == 8'hFF) && (mbx_q == MB_X_MAX) && (mby_q == MB_Y_MAX);
    end

    // Next-state and counter update. Counters move only on an accepted beat,
    // so a stalled beat keeps exactly the same counter values and therefore
    // the same registered outputs. The final accepted beat leaves the
    // counters alone and moves to DONE; the next start clears them.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        k_d     = k_q;
        mbx_d   = mbx_q;
        mby_d   = mby_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    mode_d  = mode;
                    k_d     = 8'd0;
                    mbx_d   = '0;
                    mby_d   = '0;
                end
            end

            ST_RUN: begin
                if (beat_accept) begin
                    if (at_frame_end) begin
                        state_d = ST_DONE;
                    end else begin
                        k_d = k_q + 8'd1;
                        if (k_q == 8'hFF) begin
                            if (mbx_q == MB_X_MAX) begin
                                mbx_d = '0;
                                mby_d = mby_q + MB_IDX_W'(1);
                            end else begin
                                mbx_d = mbx_q + MB_IDX_W'(1);
                            end
                        end
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Intra-macroblock offset of the beat that will be presented next.
    // In block order the high nibble of k picks the 4x4 block following the
    // H.264 zig-zag of 8x8 quadrants: b[0]/b[2] give the block column and
    // b[1]/b[3] the block row; the low nibble scans the 4x4 block in raster.
    always_comb begin
        blk_d = k_d[7:4];
        pix_d = k_d[3:0];
        if (mode_d) begin
            ox_d = {blk_d[2], blk_d[0], pix_d[1:0]};
            oy_d = {blk_d[3], blk_d[1], pix_d[3:2]};
        end else begin
            ox_d = pix_d;
            oy_d = blk_d;
        end
    end

    // Output values for the next cycle, derived from the next-state counters
    // so that every output is a flop. Outside RUN all beat outputs are forced
    // to zero; busy covers RUN and DONE, done marks the single DONE cycle.
    always_comb begin
        run_d        = (state_d == ST_RUN);
        valid_d      = run_d;
        x_out_d      = '0;
        y_out_d      = '0;
        mb_x_d       = '0;
        mb_y_d       = '0;
        blk_idx_d    = 4'd0;
        mb_first_d   = 1'b0;
        mb_last_d    = 1'b0;
        frame_last_d = 1'b0;
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);

        if (run_d) begin
            x_out_d      = (COORD_W'(mbx_d) << 4) + COORD_W'(ox_d);
            y_out_d      = (COORD_W'(mby_d) << 4) + COORD_W'(oy_d);
            mb_x_d       = mbx_d;
            mb_y_d       = mby_d;
            blk_idx_d    = blk_d;
            mb_first_d   = (k_d == 8'h00);
            mb_last_d    = (k_d == 8'hFF);
            frame_last_d = (k_d == 8'hFF) && (mbx_d == MB_X_MAX) && (mby_d == MB_Y_MAX);
        end
    end

    // Single state register for the controller, counters and outputs.
    // Reset aborts any scan at once and clears everything, with no done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= 1'b0;
            k_q          <= 8'd0;
            mbx_q        <= '0;
            mby_q        <= '0;
            valid_q      <= 1'b0;
            x_out_q      <= '0;
            y_out_q      <= '0;
            mb_x_q       <= '0;
            mb_y_q       <= '0;
            blk_idx_q    <= 4'd0;
            mb_first_q   <= 1'b0;
            mb_last_q    <= 1'b0;
            frame_last_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            k_q          <= k_d;
            mbx_q        <= mbx_d;
            mby_q        <= mby_d;
            valid_q      <= valid_d;
            x_out_q      <= x_out_d;
            y_out_q      <= y_out_d;
            mb_x_q       <= mb_x_d;
            mb_y_q       <= mb_y_d;
            blk_idx_q    <= blk_idx_d;
            mb_first_q   <= mb_first_d;
            mb_last_q    <= mb_last_d;
            frame_last_q <= frame_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign valid      = valid_q;
    assign x_out      = x_out_q;
    assign y_out      = y_out_q;
    assign mb_x       = mb_x_q;
    assign mb_y       = mb_y_q;
    assign blk_idx    = blk_idx_q;
    assign mb_first   = mb_first_q;
    assign mb_last    = mb_last_q;
    assign frame_last = frame_last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_mb_pixel_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_mb_pixel_addr_gen
//
// Scoreboard bench for mb_pixel_addr_gen on a 32x32 frame. Starting a frame
// pushes every expected beat into a queue; a negedge monitor compares the
// head of the queue against the presented beat and pops it when accepted.
// ---------------------------------------------------------------------------
module tb_mb_pixel_addr_gen;

    localparam int FW    = 32;
    localparam int FH    = 32;
    localparam int CW    = 32;
    localparam int MW    = 8;
    localparam int MBW   = FW / 16;
    localparam int BEATS = FW * FH;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic          ready;
    logic          valid;
    logic [CW-1:0] x_out;
    logic [CW-1:0] y_out;
    logic [MW-1:0] mb_x;
    logic [MW-1:0] mb_y;
    logic [3:0]    blk_idx;
    logic          mb_first;
    logic          mb_last;
    logic          frame_last;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    mb_pixel_addr_gen #(
        .FRAME_W  (FW),
        .FRAME_H  (FH),
        .COORD_W  (CW),
        .MB_IDX_W (MW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .ready      (ready),
        .valid      (valid),
        .x_out      (x_out),
        .y_out      (y_out),
        .mb_x       (mb_x),
        .mb_y       (mb_y),
        .blk_idx    (blk_idx),
        .mb_first   (mb_first),
        .mb_last    (mb_last),
        .frame_last (frame_last),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        int x;
        int y;
        int mbx;
        int mby;
        int blk;
        bit first;
        bit last;
        bit flast;
    } beat_t;

    beat_t sbQueue[$];
    int    compared   = 0;
    int    mismatched = 0;
    bit    monitorOn   = 1'b0;
    bit    modelRun    = 1'b0;
    bit    pendingDone = 1'b0;
    bit    frameDone   = 1'b0;
    int    acceptedCount = 0;
    int    uniqueCount   = 0;
    int    flastCount    = 0;
    bit    seen [FH][FW];

    // Counts one comparison and reports it when observed differs from expected
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Reference beat n of a frame, built from macroblock/block arithmetic
    function automatic beat_t modelBeat(input int n, input bit m);
        beat_t e;
        int k, mb, b, p, ox, oy;
        k  = n % 256;
        mb = n / 256;
        b  = k / 16;
        p  = k % 16;
        if (m) begin
            ox = (b % 2) * 4 + ((b / 4) % 2) * 8 + (p % 4);
            oy = ((b / 2) % 2) * 4 + (b / 8) * 8 + (p / 4);
        end else begin
            ox = p;
            oy = b;
        end
        e.mbx   = mb % MBW;
        e.mby   = mb / MBW;
        e.x     = e.mbx * 16 + ox;
        e.y     = e.mby * 16 + oy;
        e.blk   = b;
        e.first = (k == 0);
        e.last  = (k == 255);
        e.flast = (n == BEATS - 1);
        return e;
    endfunction

    // Discards every expectation after the DUT has been reset
    task automatic flushModel();
        sbQueue.delete();
        modelRun    = 1'b0;
        pendingDone = 1'b0;
    endtask

    // Negedge monitor: checks handshake/status outputs every cycle and the
    // presented beat against the scoreboard head, popping on acceptance
    always @(negedge clk) begin
        bit    doneExp;
        beat_t e;
        if (monitorOn) begin
            doneExp     = pendingDone;
            pendingDone = 1'b0;
            checkOutput("valid", 64'(valid), 64'(modelRun));
            checkOutput("done", 64'(done), 64'(doneExp));
            checkOutput("busy", 64'(busy), 64'(modelRun | doneExp));
            if (doneExp) frameDone = 1'b1;
            if (!modelRun) begin
                checkOutput("idle_xy", {x_out, y_out}, 64'd0);
                checkOutput("idle_markers",
                            64'({mb_x, mb_y, blk_idx, mb_first, mb_last, frame_last}), 64'd0);
            end else begin
                checkOutput("sb_nonempty", 64'(sbQueue.size() != 0), 64'd1);
                if (sbQueue.size() != 0) begin
                    e = sbQueue[0];
                    checkOutput("xy", {x_out, y_out}, {32'(e.x), 32'(e.y)});
                    checkOutput("mb_xy", 64'({mb_x, mb_y}), 64'({8'(e.mbx), 8'(e.mby)}));
                    checkOutput("markers", 64'({blk_idx, mb_first, mb_last, frame_last}),
                                64'({4'(e.blk), e.first, e.last, e.flast}));
                    if (ready) begin
                        void'(sbQueue.pop_front());
                        acceptedCount++;
                        if (frame_last) flastCount++;
                        if (x_out < FW && y_out < FH) begin
                            checkOutput("pixel_unique", 64'(seen[y_out][x_out]), 64'd0);
                            if (!seen[y_out][x_out]) uniqueCount++;
                            seen[y_out][x_out] = 1'b1;
                        end else begin
                            checkOutput("pixel_in_frame", {x_out, y_out}, {32'(e.x), 32'(e.y)});
                        end
                        if (e.flast) begin
                            modelRun    = 1'b0;
                            pendingDone = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Runs one frame. readyMode 0 keeps ready high; 1 stalls three cycles on
    // beat 20 then toggles ready randomly. injectStart pulses start at beat
    // 100 and in the DONE cycle; resetMid aborts the frame at beat 300.
    task automatic applyStimulus(input bit m, input int readyMode,
                                 input bit injectStart, input bit resetMid);
        int stallLeft;
        bit stalled;
        bit startInjected;
        bit aborted;
        acceptedCount = 0;
        uniqueCount   = 0;
        flastCount    = 0;
        frameDone     = 1'b0;
        foreach (seen[i, j]) seen[i][j] = 1'b0;

        @(posedge clk);
        #1;
        start = 1'b1;
        mode  = m;
        ready = 1'b1;
        for (int n = 0; n < BEATS; n++) sbQueue.push_back(modelBeat(n, m));
        @(posedge clk);
        #1;
        start    = 1'b0;
        mode     = ~m;
        modelRun = 1'b1;

        stallLeft     = 0;
        stalled       = 1'b0;
        startInjected = 1'b0;
        aborted       = 1'b0;
        for (int cyc = 0; cyc < 6000 && !frameDone && !aborted; cyc++) begin
            start = 1'b0;
            if (resetMid && acceptedCount == 300) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                flushModel();
                aborted = 1'b1;
            end else begin
                if (readyMode == 0) begin
                    ready = 1'b1;
                end else begin
                    if (!stalled && acceptedCount == 20) begin
                        stallLeft = 3;
                        stalled   = 1'b1;
                    end
                    if (stallLeft > 0) begin
                        ready = 1'b0;
                        stallLeft--;
                    end else begin
                        ready = 1'($urandom_range(0, 1));
                    end
                end
                if (injectStart && !startInjected && acceptedCount == 100) begin
                    start         = 1'b1;
                    startInjected = 1'b1;
                end
                if (injectStart && pendingDone) start = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
        ready = 1'b1;

        if (resetMid) begin
            checkOutput("reset_abort", 64'(aborted), 64'd1);
        end else begin
            checkOutput("frame_done", 64'(frameDone), 64'd1);
            checkOutput("accepted_beats", 64'(acceptedCount), 64'(BEATS));
            checkOutput("unique_pixels", 64'(uniqueCount), 64'(BEATS));
            checkOutput("frame_last_count", 64'(flastCount), 64'd1);
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        ready = 1'b0;
        @(posedge clk);
        #1;
        monitorOn = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        $display("[TB] raster scan, ready high, start pulses while busy");
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        $display("[TB] 4x4-block scan, ready high");
        applyStimulus(1'b1, 0, 1'b0, 1'b0);
        $display("[TB] raster scan with backpressure");
        applyStimulus(1'b0, 1, 1'b0, 1'b0);
        $display("[TB] block scan aborted by reset at beat 300");
        applyStimulus(1'b1, 1, 1'b0, 1'b1);
        $display("[TB] block scan after abort, backpressure");
        applyStimulus(1'b1, 1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mb_pixel_addr_gen.md
Name: mb_pixel_addr_gen

Overview:
Parametrised successor of the pixel address generator in the H.264 encoder data-handling path. On a start pulse it walks a whole frame macroblock by macroblock, in raster order of macroblocks. It emits one (x, y) pixel coordinate per accepted beat, with a selectable intra-macroblock scan: pixel raster, or H.264 4x4-block order. A valid/ready handshake lets the frame-buffer read side and the transform stage stall it; per-macroblock and end-of-frame markers frame the stream.

Parameters:
FRAME_W, 176, frame width in pixels; must be a multiple of 16.
FRAME_H, 144, frame height in pixels; must be a multiple of 16.
COORD_W, 32, width of x_out/y_out.
MB_IDX_W, 8, width of mb_x/mb_y; must hold FRAME_W/16-1 and FRAME_H/16-1.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle request to begin a frame scan; honoured only in IDLE.
mode  in  1  scan mode, sampled with start: 0 = pixel raster in MB, 1 = 4x4-block order.
ready  in  1  downstream accepts current beat.
valid  out  1  x_out/y_out/markers valid.
x_out  out  COORD_W  absolute pixel column.
y_out  out  COORD_W  absolute pixel row.
mb_x  out  MB_IDX_W  current macroblock column.
mb_y  out  MB_IDX_W  current macroblock row.
blk_idx  out  4  current 4x4 block index in MB (mode 1 order; in mode 0 = k[7:4]).
mb_first  out  1  current beat is first pixel of its MB.
mb_last  out  1  current beat is last pixel of its MB.
frame_last  out  1  current beat is last pixel of frame.
busy  out  1  high in RUN and DONE.
done  out  1  one-cycle pulse after final beat accepted.

Behaviour:
- Reset (rst=1 at an edge): state IDLE; every output 0; internal counters and latched mode 0. Reset mid-scan aborts immediately; no done pulse.
- States:
  - IDLE: start=1 latches mode, clears counters, goes to RUN.
  - RUN: valid=1. On an accepted beat (valid&&ready) that is frame_last, go to DONE.
  - DONE: valid=0, done=1 for exactly this cycle, busy=1, then IDLE.
- Latency: start sampled in IDLE at edge N; valid=1 with x_out=0, y_out=0, mb_first=1 from the cycle after edge N.
- start ignored in RUN and DONE (no restart, no effect on counters). start in the DONE cycle is ignored; next start is honoured in IDLE.
- Handshake: counters advance only on valid&&ready. With valid&&!ready, all outputs hold stable. ready is irrelevant outside RUN.
- Counters:
  - k: 8-bit intra-MB beat index 0..255.
  - mb_x: 0..FRAME_W/16-1.
  - mb_y: 0..FRAME_H/16-1.
  - k wraps 255->0 and increments mb_x; mb_x wraps to 0 and increments mb_y.
- Offsets within MB (ox, oy), 0..15:
  - mode 0: ox = k[3:0], oy = k[7:4].
  - mode 1: b = k[7:4], p = k[3:0]; ox = {b[2],b[0],p[1:0]}, oy = {b[3],b[1],p[3:2]}.
- Coordinates: x_out = mb_x*16 + ox, y_out = mb_y*16 + oy, zero-extended to COORD_W. Outputs are registered, not combinational from counters after the handshake.
- Markers (valid only while valid=1, else 0):
  - mb_first = (k==0).
  - mb_last = (k==255).
  - frame_last = mb_last && mb_x==max && mb_y==max.
- Total beats per frame = FRAME_W*FRAME_H; frame_last asserted on exactly one beat.
- mode is fixed for the whole frame; changes while busy are ignored.

Test Plan:
- Reset/idle: rst high 2 cycles, then low, start=0 for 10 cycles -> valid, busy, done, x_out, y_out all 0 throughout.
- Mode 0 raster, FRAME_W=FRAME_H=32, ready=1: pulse start -> valid next cycle. Beat 0 = (0,0) with mb_first=1. Beat 15 = (15,0). Beat 16 = (0,1). Beat 255 = (15,15) with mb_last=1. Beat 256 = (16,0) with mb_x=1. Beat 512 = (0,16) with mb_y=1. Beat 1023 = (31,31) with frame_last=1. done pulses exactly one cycle later; valid=0 in that cycle.
- Mode 1 block order, same frame: beat 4 = (0,1), beat 16 = (4,0) with blk_idx=1, beat 32 = (0,4), beat 64 = (8,0), beat 255 = (15,15). The coordinate set per MB covers all 256 pixels exactly once (scoreboard).
- Backpressure: ready=0 for 3 cycles when beat 20 is presented, then random ready at 50% -> outputs frozen during stalls; sequence identical to the ready=1 reference; total accepted beats = 1024.
- start while busy: pulse start at beat 100 and in the DONE cycle -> no counter change, no second frame; a later start from IDLE restarts at (0,0).
- Reset mid-operation: rst at beat 300 -> next cycle all outputs 0, state IDLE, no done pulse; a new start produces beat 0 = (0,0).
